// File: rtl/sample_to_pipe_out.sv
// sample_to_pipe_out
// Logging buffer from the model datapath to the host. Each 32-bit sample taken on
// sample_tick goes into a 16-bit circular FIFO as two words, low word first. The
// FIFO drains through an okBTPipeOut endpoint. The head word is first-word-fall-through:
// ep_datain shows it in the cycle after any change of the read pointer.
module sample_to_pipe_out #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  sample_tick,
  input  logic [31:0]           sample_in,
  input  logic                  ep_read,
  input  logic                  ep_blockstrobe,
  output logic [15:0]           ep_datain,
  output logic                  ep_ready,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Fill-level constants are sized to the fill counter so comparisons match in width.
  localparam logic [DEPTH_LOG2:0] FILL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] FILL_LIMIT = (DEPTH_LOG2 + 1)'(DEPTH - 2);
  localparam logic [DEPTH_LOG2:0] BLOCK_FILL = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [31:0]            hold;
  logic                   hold_load;
  logic                   wr_en;
  logic [15:0]            wr_data;
  logic                   drop;
  logic                   tick_valid;
  logic                   has_room;
  logic                   rd_en;
  logic                   empty_read;
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr_next;
  logic [DEPTH_LOG2:0]    fill_next;
  logic [15:0]            mem [DEPTH];

  // The block strobe is only a monitor point for the host interface. It has no effect on state.
  logic unused_inputs;
  assign unused_inputs = ep_blockstrobe;

  // A tick counts only while logging is enabled. The free-word check ignores any read
  // in the same cycle, so a whole sample (two words) must already fit.
  assign tick_valid = sample_tick & enable;
  assign has_room   = (fill_level <= FILL_LIMIT);

  // Read side: a read of an empty FIFO is only flagged. clear overrides both cases.
  assign rd_en       = ep_read & (fill_level != '0) & ~clear;
  assign empty_read  = ep_read & (fill_level == '0) & ~clear;
  assign rd_ptr_next = rd_en ? rd_ptr + PTR_ONE : rd_ptr;

  // Write FSM next-state, write-port control and drop detection.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and infers a latch.
    state_next = state;
    hold_load  = 1'b0;
    wr_en      = 1'b0;
    wr_data    = hold[15:0];
    drop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick_valid) begin
          if (has_room) begin
            hold_load  = 1'b1;
            state_next = WR_LO;
          end else begin
            drop = 1'b1;
          end
        end
      end
      WR_LO: begin
        wr_en      = 1'b1;
        wr_data    = hold[15:0];
        state_next = WR_HI;
        drop       = tick_valid;
      end
      WR_HI: begin
        wr_en      = 1'b1;
        wr_data    = hold[31:16];
        state_next = IDLE;
        drop       = tick_valid;
      end
      default: state_next = IDLE;
    endcase
    // A flush discards any sample in flight, and its remaining words are never written.
    if (clear) begin
      state_next = IDLE;
      hold_load  = 1'b0;
      wr_en      = 1'b0;
      drop       = 1'b0;
    end
  end

  // Net change of the fill count. A write and a read in the same cycle cancel out.
  always_comb begin
    fill_next = fill_level;
    if (wr_en && !rd_en) begin
      fill_next = fill_level + FILL_ONE;
    end else if (!wr_en && rd_en) begin
      fill_next = fill_level - FILL_ONE;
    end
  end

  // State register, pointers, fill counter and sticky flags. clear flushes them all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register see the pre-edge values, whatever the statement order.
      state      <= state_next;
      wr_ptr     <= wr_en ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr     <= rd_ptr_next;
      fill_level <= fill_next;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (empty_read) begin
        underflow <= 1'b1;
      end
    end
  end

  // Sample hold register. It is loaded when a tick is accepted in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold <= '0;
    end else if (hold_load) begin
      hold <= sample_in;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Words are never read before they are written, and a reset would stop RAM mapping.
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Head-word register. It follows the next read pointer. A word written into the head
  // slot in the same cycle is forwarded directly. When the FIFO will be empty the
  // register holds its value, so an underflow read does not disturb ep_datain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ep_datain <= '0;
    end else if (!clear && (fill_next != '0)) begin
      if (wr_en && (wr_ptr == rd_ptr_next)) begin
        ep_datain <= wr_data;
      end else begin
        ep_datain <= mem[rd_ptr_next];
      end
    end
  end

  // A host block may start once a full block is buffered.
  assign ep_ready = (fill_level >= BLOCK_FILL);

endmodule

// File: tb/tb_sample_to_pipe_out.sv
// Testbench for sample_to_pipe_out. A table of directed vectors with hand-computed
// expectations covers the short corner cases. A queue-based reference model checks
// the long sequences: block threshold, overflow at full, streaming wrap and mid-read reset.
module tb_sample_to_pipe_out;

  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;
  localparam int BW    = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          enable;
  logic          sample_tick;
  logic [31:0]   sample_in;
  logic          ep_read;
  logic          ep_blockstrobe;
  logic [15:0]   ep_datain;
  logic          ep_ready;
  logic [DL:0]   fill_level;
  logic          overflow;
  logic          underflow;

  sample_to_pipe_out #(.DEPTH_LOG2(DL), .BLOCK_WORDS(BW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .enable         (enable),
    .sample_tick    (sample_tick),
    .sample_in      (sample_in),
    .ep_read        (ep_read),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_datain      (ep_datain),
    .ep_ready       (ep_ready),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, name, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] q[$];
  int          m_stage;
  logic [31:0] m_hold;
  logic [15:0] m_data;
  bit          m_ovf;
  bit          m_unf;

  task automatic model_reset();
    q.delete();
    m_stage = 0;
    m_hold  = '0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    clear       = 1'b0;
    enable      = 1'b0;
    sample_tick = 1'b0;
    sample_in   = '0;
    ep_read     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_model();
    check("fill", 32'(fill_level), q.size());
    check("data", 32'(ep_datain), 32'(m_data));
    check("ovf", 32'(overflow), 32'(m_ovf));
    check("unf", 32'(underflow), 32'(m_unf));
    check("ready", 32'(ep_ready), (q.size() >= BW) ? 1 : 0);
  endtask

  // One clock cycle with the given inputs. Advances the model and compares after the edge.
  task automatic cycle(input bit en, input bit tick, input logic [31:0] s, input bit rd, input bit clr);
    int sz;
    enable      = en;
    sample_tick = tick;
    sample_in   = s;
    ep_read     = rd;
    clear       = clr;
    sz = q.size();
    if (clr) begin
      q.delete();
      m_stage = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      if (rd) begin
        if (sz > 0) void'(q.pop_front());
        else m_unf = 1'b1;
      end
      if (tick && en) begin
        if (m_stage == 0 && sz <= DEPTH - 2) m_hold = s;
        else m_ovf = 1'b1;
      end
      case (m_stage)
        0: if (tick && en && sz <= DEPTH - 2) m_stage = 1;
        1: begin q.push_back(m_hold[15:0]);  m_stage = 2; end
        default: begin q.push_back(m_hold[31:16]); m_stage = 0; end
      endcase
      if (q.size() > 0) m_data = q[0];
    end
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    ep_read     = 1'b0;
    clear       = 1'b0;
    check_model();
  endtask

  typedef struct {
    bit          en;
    bit          tick;
    logic [31:0] s;
    bit          rd;
    bit          clr;
    int          fill;
    logic [15:0] data;
    bit          ovf;
    bit          unf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset_n        = 1'b0;
    clear          = 1'b0;
    enable         = 1'b0;
    sample_tick    = 1'b0;
    sample_in      = '0;
    ep_read        = 1'b0;
    ep_blockstrobe = 1'b0;

    // Reset state
    phase = "reset";
    do_reset();
    check("fill", 32'(fill_level), 0);
    check("data", 32'(ep_datain), 0);
    check("ready", 32'(ep_ready), 0);
    check("ovf", 32'(overflow), 0);
    check("unf", 32'(underflow), 0);

    // Directed vectors: en, tick, sample, rd, clr -> fill, data, ovf, unf
    tbl.push_back('{1, 1, 32'h42A00000, 0, 0, 0, 16'h0000, 0, 0});  // single sample
    tbl.push_back('{1, 0, 32'h0,        0, 0, 1, 16'h0000, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 2, 16'h0000, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 1, 16'h42A0, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 0, 16'h42A0, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 0, 16'h42A0, 0, 0});
    tbl.push_back('{1, 1, 32'h11112222, 0, 0, 0, 16'h42A0, 0, 0});  // back-to-back ticks
    tbl.push_back('{1, 1, 32'h33334444, 0, 0, 1, 16'h2222, 1, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 2, 16'h2222, 1, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 1, 0, 16'h2222, 0, 0});
    tbl.push_back('{1, 1, 32'hAAAABBBB, 0, 0, 0, 16'h2222, 0, 0});  // ticks spaced 3 cycles
    tbl.push_back('{1, 0, 32'h0,        0, 0, 1, 16'hBBBB, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 2, 16'hBBBB, 0, 0});
    tbl.push_back('{1, 1, 32'hCCCCDDDD, 0, 0, 2, 16'hBBBB, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 3, 16'hBBBB, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 4, 16'hBBBB, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 3, 16'hAAAA, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 2, 16'hDDDD, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 1, 16'hCCCC, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 0, 16'hCCCC, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 0, 16'hCCCC, 0, 1});  // underflow read
    tbl.push_back('{1, 0, 32'h0,        0, 1, 0, 16'hCCCC, 0, 0});
    tbl.push_back('{1, 1, 32'h00050006, 0, 0, 0, 16'hCCCC, 0, 0});  // write+read same cycle
    tbl.push_back('{1, 0, 32'h0,        0, 0, 1, 16'h0006, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 1, 16'h0005, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 0, 16'h0005, 0, 0});
    tbl.push_back('{1, 1, 32'h77778888, 0, 0, 0, 16'h0005, 0, 0});  // clear in WR_LO
    tbl.push_back('{1, 0, 32'h0,        0, 1, 0, 16'h0005, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 0, 16'h0005, 0, 0});
    tbl.push_back('{0, 1, 32'h99990000, 0, 0, 0, 16'h0005, 0, 0});  // tick ignored when disabled
    tbl.push_back('{0, 0, 32'h0,        0, 0, 0, 16'h0005, 0, 0});
    tbl.push_back('{1, 1, 32'h1234ABCD, 0, 0, 0, 16'h0005, 0, 0});  // enable drops mid-write
    tbl.push_back('{0, 0, 32'h0,        0, 0, 1, 16'hABCD, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 0, 2, 16'hABCD, 0, 0});
    tbl.push_back('{0, 1, 32'h55556666, 0, 0, 2, 16'hABCD, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 1, 16'h1234, 0, 0});
    tbl.push_back('{1, 0, 32'h0,        1, 0, 0, 16'h1234, 0, 0});

    phase = "table";
    for (int i = 0; i < tbl.size(); i++) begin
      enable      = tbl[i].en;
      sample_tick = tbl[i].tick;
      sample_in   = tbl[i].s;
      ep_read     = tbl[i].rd;
      clear       = tbl[i].clr;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      ep_read     = 1'b0;
      clear       = 1'b0;
      check($sformatf("v%0d_fill", i), 32'(fill_level), tbl[i].fill);
      check($sformatf("v%0d_data", i), 32'(ep_datain), 32'(tbl[i].data));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("v%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
      check($sformatf("v%0d_ready", i), 32'(ep_ready), 0);
    end

    // Block threshold: 128 samples reach 256 words
    phase = "block";
    do_reset();
    for (int i = 0; i < 128; i++) begin
      cycle(1, 1, 32'(i), 0, 0);
      cycle(1, 0, 32'h0, 0, 0);
      if (i == 127) check("ready_before", 32'(ep_ready), 0);
      cycle(1, 0, 32'h0, 0, 0);
    end
    check("ready_at_256", 32'(ep_ready), 1);
    check("fill_256", 32'(fill_level), 256);
    for (int w = 0; w < 256; w++) begin
      check("order", 32'(ep_datain), (w % 2 == 0) ? (w / 2) : 0);
      cycle(1, 0, 32'h0, 1, 0);
    end
    check("drained", 32'(fill_level), 0);

    // Overflow at full
    phase = "overflow";
    do_reset();
    for (int i = 0; i < 512; i++) begin
      cycle(1, 1, {16'(i) + 16'h1000, 16'(i)}, 0, 0);
      cycle(1, 0, 32'h0, 0, 0);
      cycle(1, 0, 32'h0, 0, 0);
    end
    check("full", 32'(fill_level), 1024);
    check("no_ovf_yet", 32'(overflow), 0);
    cycle(1, 1, 32'hDEADBEEF, 0, 0);
    cycle(1, 0, 32'h0, 0, 0);
    cycle(1, 0, 32'h0, 0, 0);
    check("ovf_set", 32'(overflow), 1);
    check("full_kept", 32'(fill_level), 1024);
    check("oldest", 32'(ep_datain), 32'h0000);
    cycle(1, 0, 32'h0, 1, 0);
    check("second", 32'(ep_datain), 32'h1000);

    // Streaming with interleaved reads. Pointers wrap several times.
    phase = "wrap";
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(1, 1, {16'(i) ^ 16'h5A5A, 16'(i * 7)}, 0, 0);
      cycle(1, 0, 32'h0, q.size() > 8, 0);
      cycle(1, 0, 32'h0, q.size() > 8, 0);
    end
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      cycle(1, 0, 32'h0, 1, 0);
    end
    check("wrap_empty", 32'(fill_level), 0);
    check("wrap_no_ovf", 32'(overflow), 0);

    // Asynchronous reset during a host read
    phase = "reset_mid";
    do_reset();
    cycle(1, 1, 32'hCAFEF00D, 0, 0);
    cycle(1, 0, 32'h0, 0, 0);
    cycle(1, 0, 32'h0, 0, 0);
    check("pre_fill", 32'(fill_level), 2);
    ep_read = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    check_model();
    ep_read = 1'b0;
    reset_n = 1'b1;
    cycle(1, 0, 32'h0, 1, 0);
    check("unf_after_reset", 32'(underflow), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
